demux_scheduler: RTL and testbench



---
 rtl/demux_scheduler_if.sv | 12 +
 rtl/demux_scheduler.sv | 80 ++++++++
 tb/tb_demux_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/demux_scheduler_if.sv
// demux_scheduler_if: request/data bundle between sinks and the scheduler, plus its demux drive outputs
interface demux_scheduler_if;
    logic       enable;
    logic [7:0] req;
    logic [7:0] data;
    logic [2:0] address;
    logic       in_bit;
    logic [7:0] grant;
    logic       busy;
    modport master (output enable, req, data, input address, in_bit, grant, busy);
    modport slave  (input enable, req, data, output address, in_bit, grant, busy);
endinterface

// File: rtl/demux_scheduler.sv
// demux_scheduler: round-robin arbiter driving a shared 8-way single-bit demux
module demux_scheduler #(
    parameter int HOLD = 2
) (
    input  logic                clk,
    input  logic                rst,
    demux_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] address_q, address_d;
    logic       in_bit_q, in_bit_d;
    logic [7:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] win;
    logic [2:0] idx;
    // first requester at or after ptr; scanning offsets downward leaves the nearest one
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (bus.req[idx]) win = idx;
        end
    end
    // next-state: arbitrate in IDLE, freeze outputs through DRIVE, pulse grant in GAP
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        address_d = address_q;
        in_bit_d  = in_bit_q;
        grant_d   = '0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                in_bit_d = 1'b0;
                if (bus.enable && |bus.req) begin
                    address_d = win;
                    in_bit_d  = bus.data[win];
                    cnt_d     = 8'(HOLD - 1);
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 8'd0) begin
                    in_bit_d = 1'b0;
                    grant_d  = 8'b1 << address_q;
                    ptr_d    = address_q + 3'd1;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; reset aborts any service without a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            address_q <= '0;
            in_bit_q  <= 1'b0;
            grant_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            address_q <= address_d;
            in_bit_q  <= in_bit_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
        end
    end
    assign bus.address = address_q;
    assign bus.in_bit  = in_bit_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_demux_scheduler.sv
// tb_demux_scheduler: directed and random checks of demux_scheduler against a service-timeline model
module tb_demux_scheduler;
    localparam int HOLD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    demux_scheduler_if bus();
    demux_scheduler #(.HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // stand-in for the downstream demux: registers address/in_bit into a one-hot output
    logic [7:0] dmx;
    always_ff @(posedge clk) dmx <= rst ? 8'h00 : (8'(bus.in_bit) << bus.address);
    // model: a service is a timeline of HOLD drive cycles followed by one grant cycle
    bit       m_active = 0;
    int       m_age = 0;
    int       m_ptr = 0;
    int       m_addr = 0;
    bit       m_bit = 0;
    logic [7:0] m_dmx = 0;
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction
    function automatic logic exp_in();
        return (m_active && m_age <= HOLD) ? m_bit : 1'b0;
    endfunction
    function automatic logic [7:0] exp_grant();
        return (m_active && m_age == HOLD + 1) ? (8'h01 << m_addr) : 8'h00;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        bit         r = rst;
        bit         e = bus.enable;
        logic [7:0] rq = bus.req;
        logic [7:0] d = bus.data;
        logic [7:0] nd = r ? 8'h00 : (8'(exp_in()) << m_addr);
        @(posedge clk);
        #1;
        m_dmx = nd;
        if (r) begin
            m_active = 0; m_ptr = 0; m_addr = 0;
        end else if (m_active) begin
            if (m_age == HOLD + 1) m_active = 0;
            else begin
                m_age++;
                if (m_age == HOLD + 1) m_ptr = (m_addr + 1) % 8;
            end
        end else if (e && rq != 0) begin
            m_addr = pick(rq, m_ptr);
            m_bit = d[m_addr];
            m_active = 1;
            m_age = 1;
        end
        chk("address", 32'(bus.address), 32'(m_addr));
        chk("in_bit", 32'(bus.in_bit), 32'(exp_in()));
        chk("grant", 32'(bus.grant), 32'(exp_grant()));
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("demux_out", 32'(dmx), 32'(m_dmx));
    endtask
    task automatic run_until_grant(input int lim, output logic [7:0] g);
        g = 8'h00;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (bus.grant != 0) begin
                g = bus.grant;
                bus.req &= ~bus.grant;
                return;
            end
        end
    endtask
    initial begin
        int busy_cnt;
        bit seen20;
        int wq[$];
        int tq[$];
        logic [7:0] redo, redo_late, g;
        bus.enable = 1'b0; bus.req = 8'h00; bus.data = 8'h00;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        // single service to sink 5
        bus.enable = 1'b1; bus.req = 8'h20; bus.data = 8'h20;
        busy_cnt = 0; seen20 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (dmx == 8'h20) seen20 = 1;
            if (bus.grant != 0) bus.req &= ~bus.grant;
        end
        chk("svc5_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("svc5_demux_seen", 32'(seen20), 32'd1);
        // all sinks requesting: strict rotation from ptr 0, one grant every HOLD+2 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 8'hFF; bus.data = 8'($urandom); redo = 0; redo_late = 0;
        for (int i = 0; i < 36; i++) begin
            bus.req |= redo_late; redo_late = redo; redo = 0;
            tick();
            if (bus.grant != 0) begin
                wq.push_back($clog2(bus.grant));
                tq.push_back(i);
                redo = bus.grant;
                bus.req &= ~bus.grant;
            end
        end
        chk("rr_grant_count", 32'(wq.size()), 32'd9);
        for (int k = 0; k < wq.size(); k++) chk("rr_winner", 32'(wq[k]), 32'(k % 8));
        for (int k = 1; k < tq.size(); k++) chk("rr_period", 32'(tq[k] - tq[k-1]), 32'(HOLD + 2));
        // after serving sink 2 the scan starts at 3 and wraps to 0 before 2
        bus.req = 8'h00; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 8'h04;
        run_until_grant(10, g);
        chk("ptr_first_grant", 32'(g), 32'h04);
        tick();
        bus.req = 8'h05;
        run_until_grant(10, g);
        chk("ptr_wrap_grant", 32'(g), 32'h01);
        bus.req = 8'h00; tick(); tick();
        // enable dropped inside a service: it still completes, then arbitration stalls
        bus.req = 8'h40; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        run_until_grant(10, g);
        chk("en_drop_grant", 32'(g), 32'h40);
        bus.req = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_low_idle", 32'(bus.busy), 32'd0);
        end
        // reset mid-DRIVE aborts silently; ptr returns to 0
        bus.enable = 1'b1; bus.req = 8'h10;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_no_grant", 32'(bus.grant), 32'h00);
        bus.req = 8'h81;
        run_until_grant(10, g);
        chk("post_rst_grant", 32'(g), 32'h01);
        // random traffic: requests accumulate and are held until granted
        for (int i = 0; i < 400; i++) begin
            bus.req |= 8'($urandom) & 8'($urandom);
            bus.data = 8'($urandom);
            bus.enable = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            if (bus.grant != 0) bus.req &= ~bus.grant;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
